// File: rtl/can_pkg.sv
// Shared types and constants for the CAN 2.0A receive path.
// Holds the frame-walker states, field lengths, CRC polynomial and error codes.
package can_pkg;

    typedef enum logic [3:0] {
        ST_WAIT_IDLE,
        ST_IDLE,
        ST_ID,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_CRC_DEL,
        ST_ACK,
        ST_ACK_DEL,
        ST_EOF
    } can_state_t;

    localparam logic [14:0] CRC15_POLY = 15'h4599;

    localparam int ID_LEN    = 11;
    localparam int CTRL_LEN  = 7;   // RTR, IDE, r0, DLC[3:0]
    localparam int CRC_LEN   = 15;
    localparam int EOF_LEN   = 7;
    localparam int STUFF_RUN = 5;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_STUFF = 3'd1;
    localparam logic [2:0] ERR_FORM  = 3'd2;
    localparam logic [2:0] ERR_CRC   = 3'd3;
    localparam logic [2:0] ERR_IDE   = 3'd4;

    // Index of the last payload bit; DLC values above 8 still carry 8 bytes.
    function automatic logic [5:0] data_last_idx(input logic [3:0] dlc);
        if (dlc[3]) begin
            return 6'd63;
        end
        return {dlc[2:0], 3'b000} - 6'd1;
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15 generator, one bit per bit_en strobe.
// Shared between the receive and transmit paths.
module can_crc15
    import can_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [14:0] crc
);

    logic [14:0] r_crc;
    logic        w_feedback;

    assign w_feedback = bit_in ^ r_crc[14];

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_crc <= '0;
        end else if (bit_en) begin
            r_crc <= {r_crc[13:0], 1'b0} ^ (w_feedback ? CRC15_POLY : 15'd0);
        end
    end

    assign crc = r_crc;

endmodule

// File: rtl/can_frame_rx.sv
// CAN 2.0A standard-frame receiver: destuffs, checks CRC/form, drives ACK,
// and hands each good frame to a valid/ready consumer.
module can_frame_rx
    import can_pkg::*;
#(
    parameter int IDLE_BITS = 11,
    parameter int DATA_W    = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_en,
    input  logic              can_rx,
    output logic              can_tx,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic [10:0]       rx_id,
    output logic              rx_rtr,
    output logic [3:0]        rx_dlc,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_err,
    output logic [2:0]        rx_err_code,
    output logic              rx_overrun
);

    localparam int                IDLE_W      = $clog2(IDLE_BITS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST   = IDLE_W'(IDLE_BITS - 1);
    localparam logic [IDLE_W-1:0] IDLE_PRESET = IDLE_W'(IDLE_BITS - 3);
    localparam logic [IDLE_W-1:0] IDLE_ONE    = IDLE_W'(1);

    can_state_t r_state;
    can_state_t w_next_state;

    logic [IDLE_W-1:0] r_idle_cnt;
    logic [5:0]        r_bit_cnt;
    logic              r_run_bit;
    logic [2:0]        r_run_len;

    logic [10:0]       r_id;
    logic              r_rtr;
    logic [3:0]        r_dlc;
    logic [DATA_W-1:0] r_data;
    logic [5:0]        r_last_idx;
    logic [14:0]       r_crc_rx;

    logic              r_can_tx;
    logic              r_rx_valid;
    logic [10:0]       r_rx_id;
    logic              r_rx_rtr;
    logic [3:0]        r_rx_dlc;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_rx_err;
    logic [2:0]        r_rx_err_code;
    logic              r_rx_overrun;

    logic [14:0] w_crc;
    logic        w_stuff_zone;
    logic        w_stuff_slot;
    logic        w_sof;
    logic [3:0]  w_dlc_full;
    logic        w_err;
    logic [2:0]  w_err_code;
    logic        w_deliver;
    logic        w_ack_on;
    logic        w_ack_off;
    logic        w_crc_en;

    // CRC_DEL is included so a stuff bit following the last CRC bit is removed.
    assign w_stuff_zone = r_state inside {ST_ID, ST_CTRL, ST_DATA, ST_CRC, ST_CRC_DEL};
    assign w_stuff_slot = w_stuff_zone && (r_run_len == 3'(STUFF_RUN));
    assign w_sof        = sample_en && (r_state == ST_IDLE) && !can_rx;
    assign w_dlc_full   = {r_dlc[2:0], can_rx};

    // SOF is dominant, so skipping it leaves the zero-initialised CRC unchanged.
    can_crc15 u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state == ST_IDLE),
        .bit_en (w_crc_en),
        .bit_in (can_rx),
        .crc    (w_crc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_WAIT_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        w_err        = 1'b0;
        w_err_code   = ERR_NONE;
        w_deliver    = 1'b0;
        w_ack_on     = 1'b0;
        w_ack_off    = 1'b0;
        w_crc_en     = 1'b0;
        if (sample_en) begin
            if (w_stuff_slot) begin
                if (can_rx == r_run_bit) begin
                    w_err        = 1'b1;
                    w_err_code   = ERR_STUFF;
                    w_next_state = ST_WAIT_IDLE;
                end
            end else begin
                case (r_state)
                    ST_WAIT_IDLE: begin
                        if (can_rx && (r_idle_cnt == IDLE_LAST)) begin
                            w_next_state = ST_IDLE;
                        end
                    end
                    ST_IDLE: begin
                        if (!can_rx) begin
                            w_next_state = ST_ID;
                        end
                    end
                    ST_ID: begin
                        w_crc_en = 1'b1;
                        if (r_bit_cnt == 6'(ID_LEN - 1)) begin
                            w_next_state = ST_CTRL;
                        end
                    end
                    ST_CTRL: begin
                        w_crc_en = 1'b1;
                        if ((r_bit_cnt == 6'd1) && can_rx) begin
                            w_err        = 1'b1;
                            w_err_code   = ERR_IDE;
                            w_next_state = ST_WAIT_IDLE;
                        end else if (r_bit_cnt == 6'(CTRL_LEN - 1)) begin
                            w_next_state = (r_rtr || (w_dlc_full == 4'd0)) ? ST_CRC : ST_DATA;
                        end
                    end
                    ST_DATA: begin
                        w_crc_en = 1'b1;
                        if (r_bit_cnt == r_last_idx) begin
                            w_next_state = ST_CRC;
                        end
                    end
                    ST_CRC: begin
                        if (r_bit_cnt == 6'(CRC_LEN - 1)) begin
                            w_next_state = ST_CRC_DEL;
                        end
                    end
                    ST_CRC_DEL: begin
                        w_next_state = ST_WAIT_IDLE;
                        if (r_crc_rx != w_crc) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_CRC;
                        end else if (!can_rx) begin
                            w_err      = 1'b1;
                            w_err_code = ERR_FORM;
                        end else begin
                            w_ack_on     = 1'b1;
                            w_next_state = ST_ACK;
                        end
                    end
                    ST_ACK: begin
                        w_ack_off    = 1'b1;
                        w_next_state = ST_ACK_DEL;
                    end
                    ST_ACK_DEL: begin
                        if (!can_rx) begin
                            w_err        = 1'b1;
                            w_err_code   = ERR_FORM;
                            w_next_state = ST_WAIT_IDLE;
                        end else begin
                            w_next_state = ST_EOF;
                        end
                    end
                    ST_EOF: begin
                        if (!can_rx) begin
                            w_err        = 1'b1;
                            w_err_code   = ERR_FORM;
                            w_next_state = ST_WAIT_IDLE;
                        end else if (r_bit_cnt == 6'(EOF_LEN - 1)) begin
                            w_deliver    = 1'b1;
                            w_next_state = ST_WAIT_IDLE;
                        end
                    end
                    default: w_next_state = ST_WAIT_IDLE;
                endcase
            end
        end
    end

    // Bit-time datapath: counters, run tracking and field capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
            r_bit_cnt  <= '0;
            r_run_bit  <= 1'b1;
            r_run_len  <= '0;
            r_id       <= '0;
            r_rtr      <= 1'b0;
            r_dlc      <= '0;
            r_data     <= '0;
            r_last_idx <= '0;
            r_crc_rx   <= '0;
        end else if (sample_en) begin
            if (w_deliver) begin
                r_idle_cnt <= IDLE_PRESET;
            end else if (r_state == ST_WAIT_IDLE) begin
                r_idle_cnt <= can_rx ? (r_idle_cnt + IDLE_ONE) : '0;
            end else begin
                r_idle_cnt <= '0;
            end

            if (w_sof) begin
                r_run_bit <= 1'b0;
                r_run_len <= 3'd1;
            end else if (w_stuff_slot) begin
                r_run_bit <= can_rx;
                r_run_len <= 3'd1;
            end else if (w_stuff_zone && (r_state != ST_CRC_DEL)) begin
                if (can_rx == r_run_bit) begin
                    r_run_len <= r_run_len + 3'd1;
                end else begin
                    r_run_bit <= can_rx;
                    r_run_len <= 3'd1;
                end
            end

            if (!w_stuff_slot) begin
                r_bit_cnt <= (w_next_state != r_state) ? 6'd0 : (r_bit_cnt + 6'd1);
            end

            if (w_sof) begin
                r_id       <= '0;
                r_rtr      <= 1'b0;
                r_dlc      <= '0;
                r_data     <= '0;
                r_last_idx <= '0;
                r_crc_rx   <= '0;
            end else if (!w_stuff_slot) begin
                case (r_state)
                    ST_ID:   r_id <= {r_id[9:0], can_rx};
                    ST_CTRL: begin
                        if (r_bit_cnt == 6'd0) begin
                            r_rtr <= can_rx;
                        end
                        if (r_bit_cnt >= 6'd3) begin
                            r_dlc <= w_dlc_full;
                        end
                        if (r_bit_cnt == 6'(CTRL_LEN - 1)) begin
                            r_last_idx <= data_last_idx(w_dlc_full);
                        end
                    end
                    ST_DATA: r_data[~r_bit_cnt] <= can_rx;
                    ST_CRC:  r_crc_rx <= {r_crc_rx[13:0], can_rx};
                    default: ;
                endcase
            end
        end
    end

    // Output register, ACK drive and the consumer handshake run every clk.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_can_tx      <= 1'b1;
            r_rx_valid    <= 1'b0;
            r_rx_id       <= '0;
            r_rx_rtr      <= 1'b0;
            r_rx_dlc      <= '0;
            r_rx_data     <= '0;
            r_rx_err      <= 1'b0;
            r_rx_err_code <= ERR_NONE;
            r_rx_overrun  <= 1'b0;
        end else begin
            r_rx_err <= w_err;
            if (w_err) begin
                r_rx_err_code <= w_err_code;
            end

            if (w_ack_on) begin
                r_can_tx <= 1'b0;
            end else if (w_ack_off) begin
                r_can_tx <= 1'b1;
            end

            if (w_deliver) begin
                if (!r_rx_valid || rx_ready) begin
                    r_rx_valid <= 1'b1;
                    r_rx_id    <= r_id;
                    r_rx_rtr   <= r_rtr;
                    r_rx_dlc   <= r_dlc;
                    r_rx_data  <= r_data;
                end else begin
                    r_rx_overrun <= 1'b1;
                end
            end else if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign can_tx      = r_can_tx;
    assign rx_valid    = r_rx_valid;
    assign rx_id       = r_rx_id;
    assign rx_rtr      = r_rx_rtr;
    assign rx_dlc      = r_rx_dlc;
    assign rx_data     = r_rx_data;
    assign rx_err      = r_rx_err;
    assign rx_err_code = r_rx_err_code;
    assign rx_overrun  = r_rx_overrun;

endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx: builds stuffed CAN frames bit by bit and
// checks decoded fields, ACK timing, error codes and the output handshake.
module tb_can_frame_rx;

    localparam int BIT_CLKS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_en;
    logic        can_rx;
    logic        can_tx;
    logic        rx_valid;
    logic        rx_ready;
    logic [10:0] rx_id;
    logic        rx_rtr;
    logic [3:0]  rx_dlc;
    logic [63:0] rx_data;
    logic        rx_err;
    logic [2:0]  rx_err_code;
    logic        rx_overrun;

    int checks     = 0;
    int errors     = 0;
    int err_pulses = 0;
    int ack_clks   = 0;

    logic q[$];

    can_frame_rx #(
        .IDLE_BITS (11),
        .DATA_W    (64)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sample_en   (sample_en),
        .can_rx      (can_rx),
        .can_tx      (can_tx),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_id       (rx_id),
        .rx_rtr      (rx_rtr),
        .rx_dlc      (rx_dlc),
        .rx_data     (rx_data),
        .rx_err      (rx_err),
        .rx_err_code (rx_err_code),
        .rx_overrun  (rx_overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; observes can_tx and rx_err once per clk of the bit.
    task automatic send_bit(input logic b);
        can_rx    = b;
        sample_en = 1'b1;
        for (int i = 0; i < BIT_CLKS; i++) begin
            @(negedge clk);
            sample_en = 1'b0;
            if (!can_tx) ack_clks++;
            if (rx_err) err_pulses++;
        end
    endtask

    task automatic send_idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    task automatic send_q();
        foreach (q[i]) send_bit(q[i]);
    endtask

    // Builds SOF..CRC with stuffing, then CRC_DEL, ACK slot, ACK_DEL and EOF.
    task automatic build(input logic [10:0] id, input logic rtr, input logic ide,
                         input logic [3:0] dlc, input logic [63:0] data, input logic crc_flip);
        logic        raw[$];
        logic [14:0] crc;
        logic        fb;
        logic        prev;
        int          run;
        int          nbits;
        raw = {};
        raw.push_back(1'b0);
        for (int i = 10; i >= 0; i--) raw.push_back(id[i]);
        raw.push_back(rtr);
        raw.push_back(ide);
        raw.push_back(1'b0);
        for (int i = 3; i >= 0; i--) raw.push_back(dlc[i]);
        nbits = rtr ? 0 : ((dlc >= 4'd8) ? 64 : 8 * int'(dlc));
        for (int i = 0; i < nbits; i++) raw.push_back(data[63 - i]);
        crc = '0;
        foreach (raw[i]) begin
            fb  = raw[i] ^ crc[14];
            crc = {crc[13:0], 1'b0};
            if (fb) crc = crc ^ 15'h4599;
        end
        if (crc_flip) crc[0] = ~crc[0];
        for (int i = 14; i >= 0; i--) raw.push_back(crc[i]);
        q    = {};
        prev = 1'b1;
        run  = 0;
        foreach (raw[i]) begin
            q.push_back(raw[i]);
            if (raw[i] == prev) run++;
            else begin
                prev = raw[i];
                run  = 1;
            end
            if (run == 5) begin
                q.push_back(~prev);
                prev = ~prev;
                run  = 1;
            end
        end
        for (int i = 0; i < 10; i++) q.push_back(1'b1);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("accept_clears_valid", 64'(rx_valid), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        sample_en = 1'b0;
        can_rx    = 1'b1;
        rx_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_can_tx",   64'(can_tx),      64'd1);
        check("rst_valid",    64'(rx_valid),    64'd0);
        check("rst_id",       64'(rx_id),       64'd0);
        check("rst_data",     rx_data,          64'd0);
        check("rst_err_code", 64'(rx_err_code), 64'd0);
        check("rst_overrun",  64'(rx_overrun),  64'd0);
        rst = 1'b0;

        // Frame 1: ID 0x123, DLC 2, A5 5A
        send_idle(11);
        ack_clks = 0; err_pulses = 0;
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0);
        send_q();
        check("f1_valid",   64'(rx_valid),   64'd1);
        check("f1_id",      64'(rx_id),      64'h123);
        check("f1_dlc",     64'(rx_dlc),     64'd2);
        check("f1_rtr",     64'(rx_rtr),     64'd0);
        check("f1_data",    rx_data,         64'hA55A_0000_0000_0000);
        check("f1_ack_clk", 64'(ack_clks),   64'(BIT_CLKS));
        check("f1_no_err",  64'(err_pulses), 64'd0);
        accept();

        // ID 0, DLC 0: heavy stuffing
        send_idle(11);
        ack_clks = 0; err_pulses = 0;
        build(11'h000, 1'b0, 1'b0, 4'd0, 64'd0, 1'b0);
        send_q();
        check("f0_valid",  64'(rx_valid),   64'd1);
        check("f0_id",     64'(rx_id),      64'd0);
        check("f0_dlc",    64'(rx_dlc),     64'd0);
        check("f0_data",   rx_data,         64'd0);
        check("f0_no_err", 64'(err_pulses), 64'd0);
        accept();

        // CRC bit 0 flipped
        send_idle(11);
        ack_clks = 0; err_pulses = 0;
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b1);
        send_q();
        check("crc_no_ack",   64'(ack_clks),    64'd0);
        check("crc_err_cnt",  64'(err_pulses),  64'd1);
        check("crc_err_code", 64'(rx_err_code), 64'd3);
        check("crc_no_valid", 64'(rx_valid),    64'd0);
        send_idle(11);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0);
        send_q();
        check("crc_next_valid", 64'(rx_valid), 64'd1);
        check("crc_next_data",  rx_data,       64'hA55A_0000_0000_0000);
        accept();

        // Six dominant bits inside the ID
        send_idle(11);
        err_pulses = 0;
        q = {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        send_q();
        check("stuff_err_cnt",  64'(err_pulses),  64'd1);
        check("stuff_err_code", 64'(rx_err_code), 64'd1);
        send_idle(11);
        build(11'h7FF, 1'b0, 1'b0, 4'd8, 64'h0102_0304_0506_0708, 1'b0);
        send_q();
        check("f7ff_valid", 64'(rx_valid),   64'd1);
        check("f7ff_id",    64'(rx_id),      64'h7FF);
        check("f7ff_dlc",   64'(rx_dlc),     64'd8);
        check("f7ff_data",  rx_data,         64'h0102_0304_0506_0708);
        check("f7ff_err",   64'(err_pulses), 64'd1);
        accept();

        // IDE=1 is unsupported
        send_idle(11);
        err_pulses = 0;
        build(11'h2AA, 1'b0, 1'b1, 4'd1, 64'h1100_0000_0000_0000, 1'b0);
        send_q();
        check("ide_err_cnt",  64'(err_pulses),  64'd1);
        check("ide_err_code", 64'(rx_err_code), 64'd4);
        check("ide_no_valid", 64'(rx_valid),    64'd0);

        // DLC 12 carries 8 bytes, raw DLC reported
        send_idle(11);
        build(11'h0F0, 1'b0, 1'b0, 4'd12, 64'hDEAD_BEEF_CAFE_F00D, 1'b0);
        send_q();
        check("dlc12_dlc",  64'(rx_dlc), 64'd12);
        check("dlc12_data", rx_data,     64'hDEAD_BEEF_CAFE_F00D);
        accept();

        // Back-to-back frames with rx_ready low
        send_idle(11);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0);
        send_q();
        send_idle(3);
        build(11'h7FF, 1'b0, 1'b0, 4'd8, 64'h0102_0304_0506_0708, 1'b0);
        send_q();
        check("ovr_valid", 64'(rx_valid),   64'd1);
        check("ovr_id",    64'(rx_id),      64'h123);
        check("ovr_data",  rx_data,         64'hA55A_0000_0000_0000);
        check("ovr_flag",  64'(rx_overrun), 64'd1);
        accept();

        // Dominant 4th EOF bit
        send_idle(11);
        ack_clks = 0; err_pulses = 0;
        build(11'h555, 1'b0, 1'b0, 4'd1, 64'h3C00_0000_0000_0000, 1'b0);
        q[q.size() - 4] = 1'b0;
        send_q();
        check("form_err_cnt",  64'(err_pulses),  64'd1);
        check("form_err_code", 64'(rx_err_code), 64'd2);
        check("form_no_valid", 64'(rx_valid),    64'd0);
        check("form_keep_id",  64'(rx_id),       64'h123);
        check("form_ack_clk",  64'(ack_clks),    64'(BIT_CLKS));
        check("form_overrun",  64'(rx_overrun),  64'd1);

        // Reset in the middle of DATA
        send_idle(11);
        build(11'h123, 1'b0, 1'b0, 4'd2, 64'hA55A_0000_0000_0000, 1'b0);
        for (int i = 0; i < 25; i++) send_bit(q[i]);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_can_tx",   64'(can_tx),      64'd1);
        check("mid_rst_valid",    64'(rx_valid),    64'd0);
        check("mid_rst_id",       64'(rx_id),       64'd0);
        check("mid_rst_dlc",      64'(rx_dlc),      64'd0);
        check("mid_rst_data",     rx_data,          64'd0);
        check("mid_rst_err",      64'(rx_err),      64'd0);
        check("mid_rst_err_code", 64'(rx_err_code), 64'd0);
        check("mid_rst_overrun",  64'(rx_overrun),  64'd0);
        rst = 1'b0;
        send_idle(11);
        build(11'h7FF, 1'b0, 1'b0, 4'd8, 64'h0102_0304_0506_0708, 1'b0);
        send_q();
        check("post_rst_valid", 64'(rx_valid), 64'd1);
        check("post_rst_id",    64'(rx_id),    64'h7FF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
